// File: rtl/ex_stage_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ex_stage_pipe                                                 |
// | Brief    : Registered RV32I execute stage with valid/ready output slot.  |
// |            Optional iterative MUL enabled by macro EX_MUL_EN.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ex_stage_pipe #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic [XLEN-1:0] imm_out,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [1:0]      ALUOp,
    input  logic            ALUSrc,
    input  logic            Branch,
    input  logic            Jump,
    input  logic            Jalr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_result,
    output logic            Zero,
    output logic [XLEN-1:0] PC_next,
    output logic            branch_taken
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FULL = 2'd1
`ifdef EX_MUL_EN
        , S_MUL = 2'd2
`endif
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] result_q, pc_next_q;
    logic            zero_q, taken_q;

    logic [XLEN-1:0] opb, pc_plus4, alu_res, sra_res, jalr_sum, target;
    logic [XLEN-1:0] result_d, pc_next_d;
    logic            cond, taken_d, accept;

    assign opb      = ALUSrc ? imm_out : rdata2;
    assign pc_plus4 = pc_in + XLEN'(4);
    assign sra_res  = $signed(rdata1) >>> opb[SHW-1:0];
    assign jalr_sum = rdata1 + imm_out;

`ifdef EX_MUL_EN
    logic [XLEN-1:0] mcand_q, mplier_q, acc_q, acc_step;
    logic [SHW-1:0]  cnt_q;
    logic            is_mgrp, mul_start;

    assign is_mgrp   = (ALUOp == 2'b10) && !ALUSrc && (funct7 == 7'b0000001);
    assign mul_start = is_mgrp && (funct3 == 3'b000);
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign in_ready  = (state_q != S_MUL) && (!out_valid || out_ready);
`else
    logic unused_f7;
    assign unused_f7 = ^{funct7[6], funct7[4:0]};
    assign in_ready  = !out_valid || out_ready;
`endif

    always_comb begin
        alu_res = '0;
        case (ALUOp)
            2'b00:   alu_res = rdata1 + opb;
            2'b01:   alu_res = rdata1 - opb;
            2'b11:   alu_res = opb;
            default: begin
                case (funct3)
                    3'b000:  alu_res = (funct7[5] && !ALUSrc) ? rdata1 - opb : rdata1 + opb;
                    3'b001:  alu_res = rdata1 << opb[SHW-1:0];
                    3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(rdata1) < $signed(opb)};
                    3'b011:  alu_res = {{(XLEN-1){1'b0}}, rdata1 < opb};
                    3'b100:  alu_res = rdata1 ^ opb;
                    3'b101:  alu_res = funct7[5] ? sra_res : rdata1 >> opb[SHW-1:0];
                    3'b110:  alu_res = rdata1 | opb;
                    default: alu_res = rdata1 & opb;
                endcase
`ifdef EX_MUL_EN
                // Non-MUL members of the M group resolve to zero in one cycle.
                if (is_mgrp) alu_res = '0;
`endif
            end
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (rdata1 == rdata2);
            3'b001:  cond = (rdata1 != rdata2);
            3'b100:  cond = ($signed(rdata1) < $signed(rdata2));
            3'b101:  cond = ($signed(rdata1) >= $signed(rdata2));
            3'b110:  cond = (rdata1 < rdata2);
            3'b111:  cond = (rdata1 >= rdata2);
            default: cond = 1'b0;
        endcase
    end

    assign taken_d   = (Branch && cond) || Jump || Jalr;
    assign target    = Jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_in + imm_out;
    assign pc_next_d = taken_d ? target : pc_plus4;
    assign result_d  = (Jump || Jalr) ? pc_plus4 : alu_res;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            pc_next_q <= '0;
            zero_q    <= 1'b0;
            taken_q   <= 1'b0;
`ifdef EX_MUL_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
`endif
        end else if (flush) begin
            state_q <= S_IDLE;
`ifdef EX_MUL_EN
            cnt_q   <= '0;
`endif
        end else if (accept) begin
            pc_next_q <= pc_next_d;
            taken_q   <= taken_d;
`ifdef EX_MUL_EN
            if (mul_start) begin
                state_q  <= S_MUL;
                mcand_q  <= rdata1;
                mplier_q <= rdata2;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else
`endif
            begin
                state_q  <= S_FULL;
                result_q <= result_d;
                zero_q   <= (result_d == '0);
            end
        end
`ifdef EX_MUL_EN
        else if (state_q == S_MUL) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            // The result slot is only written once the final partial sum is known.
            if (cnt_q == SHW'(XLEN - 1)) begin
                state_q  <= S_FULL;
                result_q <= acc_step;
                zero_q   <= (acc_step == '0);
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + SHW'(1);
            end
        end
`endif
        else if ((state_q == S_FULL) && out_ready) begin
            state_q <= S_IDLE;
        end
    end

    assign out_valid    = (state_q == S_FULL);
    assign ALU_result   = result_q;
    assign Zero         = zero_q;
    assign PC_next      = pc_next_q;
    assign branch_taken = taken_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ex_stage_pipe                                              |
// | Brief    : Self-checking bench for ex_stage_pipe (model + random ops).   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_ex_stage_pipe;

    localparam int XLEN = 32;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, Zero, branch_taken;
    logic [31:0] pc_in = '0, rdata1 = '0, rdata2 = '0, imm_out = '0;
    logic [31:0] ALU_result, PC_next;
    logic [6:0]  funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic [1:0]  ALUOp  = '0;
    logic        ALUSrc = 1'b0, Branch = 1'b0, Jump = 1'b0, Jalr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage_pipe #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .rdata1(rdata1), .rdata2(rdata2), .imm_out(imm_out),
        .funct7(funct7), .funct3(funct3), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
        .Branch(Branch), .Jump(Jump), .Jalr(Jalr),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_result(ALU_result), .Zero(Zero), .PC_next(PC_next),
        .branch_taken(branch_taken)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] pcn;
        logic        tk;
    } exp_t;

    logic m_full = 1'b0;
    logic m_acc  = 1'b0;
    exp_t m_exp  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic lt_s(input logic [31:0] x, input logic [31:0] y);
        return (x ^ 32'h8000_0000) < (y ^ 32'h8000_0000);
    endfunction

    // Instruction semantics straight from the ISA rules, on the current inputs.
    function automatic exp_t ref_model();
        exp_t        e;
        logic [31:0] a, b, r;
        logic [4:0]  s;
        logic        c;
        a = rdata1;
        b = ALUSrc ? imm_out : rdata2;
        s = b[4:0];
        case (ALUOp)
            2'b00:   r = a + b;
            2'b01:   r = a + ~b + 32'd1;
            2'b11:   r = b;
            default: begin
                case (funct3)
                    3'd0:    r = (funct7[5] && !ALUSrc) ? a + ~b + 32'd1 : a + b;
                    3'd1:    r = a << s;
                    3'd2:    r = 32'(lt_s(a, b));
                    3'd3:    r = 32'(a < b);
                    3'd4:    r = a ^ b;
                    3'd5:    r = (a >> s) | ((funct7[5] && a[31]) ? ~(32'hFFFF_FFFF >> s) : 32'h0);
                    3'd6:    r = a | b;
                    default: r = a & b;
                endcase
            end
        endcase
        case (funct3)
            3'd0:    c = (rdata1 == rdata2);
            3'd1:    c = (rdata1 != rdata2);
            3'd4:    c = lt_s(rdata1, rdata2);
            3'd5:    c = !lt_s(rdata1, rdata2);
            3'd6:    c = (rdata1 < rdata2);
            3'd7:    c = !(rdata1 < rdata2);
            default: c = 1'b0;
        endcase
        e.tk  = (Branch && c) || Jump || Jalr;
        e.pcn = !e.tk ? pc_in + 32'd4 :
                Jalr  ? ((rdata1 + imm_out) & ~32'd1) : pc_in + imm_out;
        e.res = (Jump || Jalr) ? pc_in + 32'd4 : r;
        return e;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        logic rdy;
        #1;
        rdy = !m_full || out_ready;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        m_acc = in_valid && rdy && !flush;
        if (flush)                    m_full = 1'b0;
        else if (m_acc)               begin m_full = 1'b1; m_exp = ref_model(); end
        else if (m_full && out_ready) m_full = 1'b0;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_full));
        if (m_full) begin
            chk("ALU_result", ALU_result, m_exp.res);
            chk("PC_next", PC_next, m_exp.pcn);
            chk("branch_taken", 32'(branch_taken), 32'(m_exp.tk));
            chk("Zero", 32'(Zero), 32'(m_exp.res == 32'd0));
        end
    endtask

    task automatic set_ops(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [6:0] f7, input logic [2:0] f3,
                           input logic [1:0] op, input logic src, input logic br,
                           input logic j, input logic jr);
        pc_in = pc; rdata1 = a; rdata2 = b; imm_out = imm; funct7 = f7; funct3 = f3;
        ALUOp = op; ALUSrc = src; Branch = br; Jump = j; Jalr = jr;
    endtask

    task automatic rand_insn();
        int          k;
        logic [31:0] r;
        k = $urandom_range(0, 3);
        r = $urandom;
        pc_in   = $urandom & ~32'd3;
        rdata1  = $urandom;
        rdata2  = ($urandom_range(0, 5) == 0) ? rdata1 : $urandom;
        imm_out = ($urandom_range(0, 1) == 1) ? {{20{r[11]}}, r[11:0]} : {27'd0, r[4:0]};
        funct7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        funct3  = 3'($urandom);
        ALUOp   = 2'($urandom);
        ALUSrc  = 1'($urandom);
        Branch  = (k == 1);
        Jump    = (k == 2);
        Jalr    = (k == 3);
    endtask

    initial begin
        int idx, cyc;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ALU_result", ALU_result, 32'd0);
        chk("rst_PC_next", PC_next, 32'd0);
        chk("rst_Zero", 32'(Zero), 32'd0);
        chk("rst_taken", 32'(branch_taken), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        in_valid = 1'b1; out_ready = 1'b1;
        set_ops(32'h0, 32'd5, 32'd7, 32'd0, 7'h20, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("sub_result", ALU_result, 32'hFFFF_FFFE);
        chk("sub_pcn", PC_next, 32'h4);

        set_ops(32'h100, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 7'h00, 3'b110, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("bltu_taken", 32'(branch_taken), 32'd1);
        chk("bltu_pcn", PC_next, 32'hF0);
        funct3 = 3'b100;
        cycle();
        chk("blt_taken", 32'(branch_taken), 32'd0);
        chk("blt_pcn", PC_next, 32'h104);

        set_ops(32'h40, 32'h2003, 32'd0, 32'd4, 7'h00, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("jalr_pcn", PC_next, 32'h2006);
        chk("jalr_result", ALU_result, 32'h44);

        set_ops(32'h0, 32'h8000_0000, 32'h21, 32'd0, 7'h20, 3'b101, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("sra_result", ALU_result, 32'hC000_0000);

        // Four ADDs streamed back to back, downstream stalls for two cycles.
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 12) begin
            set_ops(32'h1000 + 32'(idx * 4), 32'(idx * 100 + 1), 32'(idx + 7), 32'd0,
                    7'h00, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
            out_ready = !(cyc == 1 || cyc == 2);
            cycle();
            if (m_acc) idx++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();

        repeat (400) begin
            rand_insn();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 9) == 0);
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset while the slot is full.
        set_ops(32'h80, 32'd3, 32'd4, 32'd0, 7'h00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_ALU_result", ALU_result, 32'd0);
        m_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

`ifdef EX_MUL_EN
        begin
            int bad;
            set_ops(32'h0, 32'h12345, 32'h10, 32'd0, 7'h01, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
            in_valid = 1'b1; out_ready = 1'b1;
            #1 chk("mul_accept_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            bad = 0;
            for (int i = 1; i <= 32; i++) begin
                if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
                @(negedge clk);
            end
            chk("mul_busy_cycles", 32'(bad), 32'd0);
            chk("mul_out_valid", 32'(out_valid), 32'd1);
            chk("mul_result", ALU_result, 32'h0012_3450);
            @(negedge clk);

            in_valid = 1'b1;
            #1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (9) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk("mul_flush_ready", 32'(in_ready), 32'd1);
            bad = 0;
            for (int i = 0; i < 40; i++) begin
                if (out_valid !== 1'b0) bad++;
                @(negedge clk);
            end
            chk("mul_flush_no_valid", 32'(bad), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
